// File: rtl/sopc_bus.sv
// Single-master bus bridge: decodes the core address to one of NSLV slaves, serializes write-then-read,
// and aborts to an error pulse on an unmapped address or an ack timeout.
module sopc_bus #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int NSLV = 4,
  parameter logic [NSLV*AW-1:0] SLV_BASE = {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000},
  parameter logic [NSLV*AW-1:0] SLV_MASK = {4{32'hF000_0000}},
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               m_re_i,
  input  logic [AW-1:0]      m_raddr_i,
  input  logic               m_we_i,
  input  logic [AW-1:0]      m_waddr_i,
  input  logic [DW-1:0]      m_wdata_i,
  output logic [DW-1:0]      m_rdata_o,
  output logic               m_stall_o,
  output logic               m_err_o,
  output logic [AW-1:0]      s_addr_o,
  output logic [DW-1:0]      s_wdata_o,
  output logic [NSLV-1:0]    s_re_o,
  output logic [NSLV-1:0]    s_we_o,
  input  logic [NSLV*DW-1:0] s_rdata_i,
  input  logic [NSLV-1:0]    s_ack_i
);

  localparam int SW = (NSLV > 1) ? $clog2(NSLV) : 1;
  localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

  typedef enum logic [2:0] {IDLE, WR, RD, ERR, DONE} state_t;

  state_t          state, state_nxt;
  logic            we_l, re_l;
  logic [AW-1:0]   waddr_l, raddr_l;
  logic [DW-1:0]   wdata_l;
  logic [CW-1:0]   cnt;

  logic            req, cap_re;
  logic [AW-1:0]   cap_waddr, cap_raddr;
  logic [DW-1:0]   cap_wdata;
  logic            wmap, rmap, wack, rack, timed_out;
  logic [SW-1:0]   wsel, rsel;

  // Returns {hit, index}; scanning downward leaves the lowest matching slave selected.
  function automatic logic [SW:0] decode(input logic [AW-1:0] a);
    logic          hit;
    logic [SW-1:0] sel;
    hit = 1'b0;
    sel = '0;
    for (int k = NSLV - 1; k >= 0; k--) begin
      if ((a & SLV_MASK[k*AW +: AW]) == SLV_BASE[k*AW +: AW]) begin
        hit = 1'b1;
        sel = SW'(k);
      end
    end
    return {hit, sel};
  endfunction

  // In IDLE the decision is made on the live core inputs, afterwards on the latched copy.
  assign req       = m_re_i | m_we_i;
  assign cap_re    = (state == IDLE) ? m_re_i    : re_l;
  assign cap_waddr = (state == IDLE) ? m_waddr_i : waddr_l;
  assign cap_raddr = (state == IDLE) ? m_raddr_i : raddr_l;
  assign cap_wdata = (state == IDLE) ? m_wdata_i : wdata_l;

  assign {wmap, wsel} = decode(cap_waddr);
  assign {rmap, rsel} = decode(cap_raddr);
  assign wack      = s_ack_i[wsel];
  assign rack      = s_ack_i[rsel];
  assign timed_out = (cnt == CW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (m_we_i) state_nxt = wmap ? WR : ERR;
          else        state_nxt = rmap ? RD : ERR;
        end
      end
      WR: begin
        if (wack)           state_nxt = cap_re ? (rmap ? RD : ERR) : DONE;
        else if (timed_out) state_nxt = ERR;
      end
      RD: begin
        if (rack)           state_nxt = DONE;
        else if (timed_out) state_nxt = ERR;
      end
      ERR:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign m_stall_o = (state == IDLE) ? req : (state != DONE);
  assign s_we_o    = (state == WR) ? (NSLV'(1) << wsel) : '0;
  assign s_re_o    = (state == RD) ? (NSLV'(1) << rsel) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      we_l      <= 1'b0;
      re_l      <= 1'b0;
      waddr_l   <= '0;
      raddr_l   <= '0;
      wdata_l   <= '0;
      cnt       <= '0;
      s_addr_o  <= '0;
      s_wdata_o <= '0;
      m_rdata_o <= '0;
      m_err_o   <= 1'b0;
    end else begin
      state   <= state_nxt;
      m_err_o <= (state == ERR);

      if (state == IDLE && req) begin
        we_l    <= m_we_i;
        re_l    <= m_re_i;
        waddr_l <= m_waddr_i;
        raddr_l <= m_raddr_i;
        wdata_l <= m_wdata_i;
      end else if (state == DONE) begin
        we_l <= 1'b0;
        re_l <= 1'b0;
      end

      // Wait counter restarts whenever WR or RD is entered, including the WR->RD hand-over.
      if ((state_nxt == WR || state_nxt == RD) && state_nxt == state) cnt <= cnt + 1'b1;
      else                                                             cnt <= '0;

      if (state_nxt == WR && state != WR) begin
        s_addr_o  <= cap_waddr;
        s_wdata_o <= cap_wdata;
      end else if (state_nxt == RD && state != RD) begin
        s_addr_o  <= cap_raddr;
      end

      if (state == RD) begin
        if (rack)           m_rdata_o <= s_rdata_i[int'(rsel)*DW +: DW];
        else if (timed_out) m_rdata_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_sopc_bus.sv
// Directed bench for sopc_bus: decode, write-before-read ordering, unmapped access,
// ack timeout, ack filtering and asynchronous reset mid-transfer.
module tb_sopc_bus;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          m_re_i = 1'b0;
  logic [31:0]   m_raddr_i = '0;
  logic          m_we_i = 1'b0;
  logic [31:0]   m_waddr_i = '0;
  logic [31:0]   m_wdata_i = '0;
  logic [31:0]   m_rdata_o;
  logic          m_stall_o;
  logic          m_err_o;
  logic [31:0]   s_addr_o;
  logic [31:0]   s_wdata_o;
  logic [3:0]    s_re_o;
  logic [3:0]    s_we_o;
  logic [127:0]  s_rdata_i = '0;
  logic [3:0]    s_ack_i = '0;

  int n_chk = 0;
  int n_fail = 0;

  // Slave 3 gets an all-zero mask so its 0x3000_0000 base can never match.
  sopc_bus #(
    .AW(32), .DW(32), .NSLV(4),
    .SLV_BASE({32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}),
    .SLV_MASK({32'h0000_0000, 32'hF000_0000, 32'hF000_0000, 32'hF000_0000}),
    .TIMEOUT(15)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_re_i(m_re_i), .m_raddr_i(m_raddr_i),
    .m_we_i(m_we_i), .m_waddr_i(m_waddr_i), .m_wdata_i(m_wdata_i),
    .m_rdata_o(m_rdata_o), .m_stall_o(m_stall_o), .m_err_o(m_err_o),
    .s_addr_o(s_addr_o), .s_wdata_o(s_wdata_o),
    .s_re_o(s_re_o), .s_we_o(s_we_o),
    .s_rdata_i(s_rdata_i), .s_ack_i(s_ack_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then let combinational outputs settle.
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int strobes;
    int done_seen;

    // Reset state
    step();
    check("rst_rdata", m_rdata_o, 0);
    check("rst_err",   m_err_o, 0);
    check("rst_re",    s_re_o, 0);
    check("rst_we",    s_we_o, 0);
    check("rst_addr",  s_addr_o, 0);
    check("rst_wdata", s_wdata_o, 0);
    check("rst_stall", m_stall_o, 0);
    rst_n = 1'b1;

    // Read slave 1 with immediate ack
    step();
    s_rdata_i[63:32] = 32'hDEAD_BEEF;
    s_ack_i   = 4'b0010;
    m_re_i    = 1'b1;
    m_raddr_i = 32'h1000_0004;
    #1 check("rd1_stall_idle", m_stall_o, 1);
    step();
    check("rd1_re",    s_re_o, 4'b0010);
    check("rd1_addr",  s_addr_o, 32'h1000_0004);
    check("rd1_stall", m_stall_o, 1);
    step();
    check("rd1_done_stall", m_stall_o, 0);
    check("rd1_rdata",      m_rdata_o, 32'hDEAD_BEEF);
    check("rd1_done_re",    s_re_o, 0);
    check("rd1_err",        m_err_o, 0);
    m_re_i  = 1'b0;
    s_ack_i = 4'b0000;
    step();
    check("rd1_idle_stall", m_stall_o, 0);

    // Simultaneous write to slave 2 and read from slave 0
    s_rdata_i[31:0] = 32'hCAFE_F00D;
    s_ack_i   = 4'b0101;
    m_we_i    = 1'b1;
    m_waddr_i = 32'h2000_0010;
    m_wdata_i = 32'h1234_5678;
    m_re_i    = 1'b1;
    m_raddr_i = 32'h0000_0008;
    step();
    check("wr_we",    s_we_o, 4'b0100);
    check("wr_re",    s_re_o, 0);
    check("wr_addr",  s_addr_o, 32'h2000_0010);
    check("wr_wdata", s_wdata_o, 32'h1234_5678);
    step();
    check("wrrd_re",   s_re_o, 4'b0001);
    check("wrrd_we",   s_we_o, 0);
    check("wrrd_addr", s_addr_o, 32'h0000_0008);
    step();
    check("wrrd_done_stall", m_stall_o, 0);
    check("wrrd_rdata",      m_rdata_o, 32'hCAFE_F00D);
    check("wrrd_addr_hold",  s_addr_o, 32'h0000_0008);
    m_we_i  = 1'b0;
    m_re_i  = 1'b0;
    s_ack_i = 4'b0000;
    step();

    // Unmapped write (slave 3 disabled)
    m_we_i    = 1'b1;
    m_waddr_i = 32'h4000_0000;
    step();
    check("unm_we",    s_we_o, 0);
    check("unm_re",    s_re_o, 0);
    check("unm_stall", m_stall_o, 1);
    check("unm_err_early", m_err_o, 0);
    step();
    check("unm_err",   m_err_o, 1);
    check("unm_stall_done", m_stall_o, 0);
    m_we_i = 1'b0;
    step();
    check("unm_err_once", m_err_o, 0);

    // Read slave 2 with no ack: timeout
    m_re_i    = 1'b1;
    m_raddr_i = 32'h2000_0000;
    strobes   = 0;
    done_seen = 0;
    for (int i = 0; i < 40 && done_seen == 0; i++) begin
      step();
      if (s_re_o == 4'b0100) strobes++;
      if (!m_stall_o) done_seen = 1;
    end
    check("to_done_reached", done_seen, 1);
    check("to_strobes", strobes, 15);
    check("to_err",     m_err_o, 1);
    check("to_rdata",   m_rdata_o, 0);
    m_re_i = 1'b0;
    step();

    // Slave 3 ack during slave 0 read is ignored
    s_rdata_i[31:0]   = 32'h55AA_55AA;
    s_rdata_i[127:96] = 32'hFFFF_0000;
    s_ack_i   = 4'b1000;
    m_re_i    = 1'b1;
    m_raddr_i = 32'h0000_0010;
    step();
    check("flt_re0", s_re_o, 4'b0001);
    step();
    check("flt_re1",    s_re_o, 4'b0001);
    check("flt_stall1", m_stall_o, 1);
    s_ack_i = 4'b0001;
    step();
    check("flt_done_stall", m_stall_o, 0);
    check("flt_rdata",      m_rdata_o, 32'h55AA_55AA);
    m_re_i  = 1'b0;
    s_ack_i = 4'b0000;
    step();

    // Reset pulsed mid-write
    m_we_i    = 1'b1;
    m_waddr_i = 32'h1000_0020;
    m_wdata_i = 32'hA5A5_A5A5;
    step();
    check("mrst_we_before", s_we_o, 4'b0010);
    rst_n = 1'b0;
    #1;
    check("mrst_we",    s_we_o, 0);
    check("mrst_addr",  s_addr_o, 0);
    check("mrst_wdata", s_wdata_o, 0);
    check("mrst_rdata", m_rdata_o, 0);
    check("mrst_stall_req", m_stall_o, 1);
    m_we_i = 1'b0;
    #1 check("mrst_stall_idle", m_stall_o, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("mrst_no_err", m_err_o, 0);
    end
    s_rdata_i[63:32] = 32'h0BAD_F00D;
    s_ack_i   = 4'b0010;
    m_re_i    = 1'b1;
    m_raddr_i = 32'h1000_0004;
    step();
    check("mrst_idle_rd", s_re_o, 4'b0010);
    step();
    check("mrst_rd_rdata", m_rdata_o, 32'h0BAD_F00D);
    m_re_i  = 1'b0;
    s_ack_i = 4'b0000;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sopc_bus.md
SOPC_BUS -- requirements
Module: sopc_bus

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- AW, 32: address width.
- DW, 32: data width.
- NSLV, 4: number of slave ports.
- SLV_BASE, {32'h3000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000}: per-slave base address, concatenated, slave 0 in the LSBs.
- SLV_MASK, {4{32'hF000_0000}}: per-slave decode mask, concatenated.
- TIMEOUT, 15: maximum wait cycles for a slave ack.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1: clock, all state on rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- m_re_i, in, 1: core read request.
- m_raddr_i, in, AW: core read address.
- m_we_i, in, 1: core write request.
- m_waddr_i, in, AW: core write address.
- m_wdata_i, in, DW: core write data.
- m_rdata_o, out, DW: registered read data.
- m_stall_o, out, 1: core must hold its request and stall.
- m_err_o, out, 1: transfer error, one-cycle pulse.
- s_addr_o, out, AW: shared slave address.
- s_wdata_o, out, DW: shared slave write data.
- s_re_o, out, NSLV: per-slave read strobe.
- s_we_o, out, NSLV: per-slave write strobe.
- s_rdata_i, in, NSLV*DW: per-slave read data, concatenated, slave 0 in the LSBs.
- s_ack_i, in, NSLV: per-slave completion ack.

Function
REQ-003 Decode: the block SHALL select slave k when (addr & SLV_MASK[k]) == SLV_BASE[k]; if several slaves match, the lowest k wins; if none match, the address is unmapped.
REQ-004 States: the FSM SHALL have exactly five states: IDLE, WR, RD, ERR, DONE.
REQ-005 IDLE: on m_we_i or m_re_i, the block SHALL latch both requests, both addresses and the write data, then go to WR if the write is pending, otherwise to RD.
REQ-006 Unmapped access: if the latched access to be issued is unmapped, the block SHALL go to ERR instead of WR or RD, and SHALL NOT assert any s_re_o or s_we_o bit.
REQ-007 Stall: m_stall_o SHALL be asserted combinationally in IDLE when (m_re_i | m_we_i), and in WR, RD and ERR; it SHALL be 0 in DONE and in IDLE with no request.
REQ-008 WR state: the block SHALL assert s_we_o[sel] (one-hot), s_addr_o = latched waddr and s_wdata_o = latched wdata.
- Exit on s_ack_i[sel]: to RD if a read is also latched, else to DONE.
- A simultaneous read and write SHALL therefore complete the write before the read.
REQ-009 RD state: the block SHALL assert s_re_o[sel] (one-hot) with s_addr_o = latched raddr; on s_ack_i[sel] it SHALL register the selected DW slice of s_rdata_i into m_rdata_o and go to DONE.
REQ-010 Ack filtering: acks from non-selected slaves SHALL be ignored.
REQ-011 Timeout: a 4-bit-minimum wait counter SHALL clear on entry to WR/RD and increment each cycle without ack.
- When the counter reaches TIMEOUT, the block SHALL abort to ERR.
- An aborted read SHALL load m_rdata_o with 0.
REQ-012 ERR state: lasts one cycle, then goes to DONE; m_err_o SHALL pulse high in the DONE cycle that follows ERR.
REQ-013 DONE state: lasts one cycle, with m_stall_o = 0 so the core retires the access, then returns to IDLE.
- Core inputs sampled in the DONE cycle SHALL be ignored.
- The earliest next transfer is captured in the following IDLE cycle.
REQ-014 Latency: a mapped write or read with an ack on its first strobe cycle SHALL release the stall after 2 cycles (IDLE capture, WR/RD, DONE).
REQ-015 Idle outputs: when not in WR or RD, s_re_o and s_we_o SHALL be all zero; s_addr_o and s_wdata_o hold their last values.
REQ-016 Data hold: m_rdata_o SHALL hold its value until the next completed or aborted read.

Reset
REQ-017 When rst_n is low, asynchronously:
- state = IDLE, wait counter = 0, latched requests cleared.
- m_rdata_o = 0, m_err_o = 0.
- s_re_o = 0, s_we_o = 0, s_addr_o = 0, s_wdata_o = 0.
- m_stall_o then follows REQ-007.
REQ-018 Reset asserted mid-transfer SHALL abandon the transfer with no error pulse; after release, the block SHALL be in IDLE.

Verification
REQ-019 Read of 0x1000_0004 with slave 1 acking immediately and s_rdata slice 1 = 0xDEAD_BEEF -> s_re_o = 4'b0010 for one cycle, m_rdata_o = 0xDEAD_BEEF, stall high for 2 cycles, m_err_o = 0.
REQ-020 Simultaneous write to 0x2000_0010 (data 0x1234_5678) and read from 0x0000_0008 -> s_we_o = 4'b0100 first, then s_re_o = 4'b0001, then DONE.
REQ-021 With SLV_MASK[3] changed to 0, write to 0x4000_0000 -> no strobes, ERR then DONE, m_err_o pulses once.
REQ-022 Read of slave 2 with s_ack_i held low -> s_re_o[2] high for exactly TIMEOUT cycles, m_err_o pulses, m_rdata_o = 0.
REQ-023 Ack from slave 3 during a slave 0 read -> ignored; the transfer completes only on s_ack_i[0].
REQ-024 rst_n pulsed low during WR with ack pending -> outputs clear immediately, state IDLE, no m_err_o pulse.
